// File: rtl/iter_divider.sv
// Radix-2 restoring divider: captures dividend and divisor on independent valid/ready channels,
// retires one quotient bit per cycle and strobes {quotient, remainder} for one cycle when done.
module iter_divider #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state;

    logic               dvd_flag, dvs_flag;
    logic [WIDTH-1:0]   dvd_lat, dvs_lat;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   quo_sh;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   dvd_raw;
    logic               qsign, rsign, div_zero;
    logic [2*WIDTH-1:0] dout;

    // Input channels transfer on a rising edge where tvalid && tready; a source that sees tready=0
    // holds tvalid. The output channel is valid-only: tvalid is a one-cycle strobe with no backpressure.
    assign s_axis_dividend_tready = (state == IDLE) && !dvd_flag;
    assign s_axis_divisor_tready  = (state == IDLE) && !dvs_flag;
    assign m_axis_dout_tvalid     = (state == DONE);
    assign m_axis_dout_tdata      = dout;

    logic dvd_fire, dvs_fire, start;
    assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign start    = (state == IDLE) && (dvd_flag || dvd_fire) && (dvs_flag || dvs_fire);

    // Operands as seen on the start edge: a channel completing this cycle bypasses its latch.
    logic [WIDTH-1:0] dvd_now, dvs_now, dvd_abs, dvs_abs;
    logic             sa, sb;
    always_comb begin
        dvd_now = dvd_fire ? s_axis_dividend_tdata : dvd_lat;
        dvs_now = dvs_fire ? s_axis_divisor_tdata : dvs_lat;
        sa      = SIGNED && dvd_now[WIDTH-1];
        sb      = SIGNED && dvs_now[WIDTH-1];
        dvd_abs = sa ? -dvd_now : dvd_now;
        dvs_abs = sb ? -dvs_now : dvs_now;
    end

    // One restoring step; the partial remainder gains one bit before the trial subtraction.
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   diff, rem_next, quo_next, q_fix, r_fix;
    logic [2*WIDTH-1:0] result;
    always_comb begin
        shifted  = {rem, quo_sh[WIDTH-1]};
        ge       = shifted >= {1'b0, dvs_mag};
        diff     = shifted[WIDTH-1:0] - dvs_mag;
        rem_next = ge ? diff : shifted[WIDTH-1:0];
        quo_next = {quo_sh[WIDTH-2:0], ge};
        q_fix    = qsign ? -quo_next : quo_next;
        r_fix    = rsign ? -rem_next : rem_next;
        result   = div_zero ? {{WIDTH{1'b1}}, dvd_raw} : {q_fix, r_fix};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dvd_flag <= 1'b0;
            dvs_flag <= 1'b0;
            count    <= '0;
            dout     <= '0;
        end else if (abort) begin
            state    <= IDLE;
            dvd_flag <= 1'b0;
            dvs_flag <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dvd_fire) begin
                        dvd_lat  <= s_axis_dividend_tdata;
                        dvd_flag <= 1'b1;
                    end
                    if (dvs_fire) begin
                        dvs_lat  <= s_axis_divisor_tdata;
                        dvs_flag <= 1'b1;
                    end
                    if (start) begin
                        state    <= RUN;
                        quo_sh   <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        dvd_raw  <= dvd_now;
                        rem      <= '0;
                        count    <= '0;
                        qsign    <= sa ^ sb;
                        rsign    <= sa;
                        div_zero <= (dvs_now == '0);
                    end
                end
                RUN: begin
                    rem    <= rem_next;
                    quo_sh <= quo_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                        dout  <= result;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    dvd_flag <= 1'b0;
                    dvs_flag <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: unsigned and signed instances share stimulus and are checked every cycle
// against a transaction-level model of capture, latency, abort/reset and the arithmetic result.
module tb_iter_divider;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, abort;
    logic [W-1:0]   dvd_data, dvs_data;
    logic           dvd_valid, dvs_valid;
    logic           u_dvd_ready, u_dvs_ready, u_valid;
    logic           s_dvd_ready, s_dvs_ready, s_valid;
    logic [2*W-1:0] u_data, s_data;

    iter_divider #(.WIDTH(W), .SIGNED(1'b0)) u_divu (
        .clk(clk), .reset(reset), .abort(abort),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(u_dvd_ready),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
        .s_axis_divisor_tready(u_dvs_ready),
        .m_axis_dout_tdata(u_data), .m_axis_dout_tvalid(u_valid)
    );

    iter_divider #(.WIDTH(W), .SIGNED(1'b1)) u_div (
        .clk(clk), .reset(reset), .abort(abort),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
        .s_axis_dividend_tready(s_dvd_ready),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
        .s_axis_divisor_tready(s_dvs_ready),
        .m_axis_dout_tdata(s_data), .m_axis_dout_tvalid(s_valid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_u(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    function automatic logic [63:0] ref_s(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {32'hFFFF_FFFF, a};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Transaction model: captured flags, one op in flight, its due cycle and the last shown result.
    bit             mon_en = 1'b0;
    bit             m_busy = 1'b0, m_got_a = 1'b0, m_got_b = 1'b0;
    int             m_due;
    logic [W-1:0]   m_a, m_b;
    logic [63:0]    m_last_u = '0, m_last_s = '0;
    logic [127:0]   exp_q[$];
    logic [127:0]   ent;
    logic [63:0]    obs_u, obs_s;
    bit             exp_v;
    logic [1:0]     exp_rdy;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_v   = m_busy && (cyc == m_due);
            exp_rdy = {!m_busy && !m_got_a, !m_busy && !m_got_b};
            ent     = {m_last_u, m_last_s};
            if (exp_v && exp_q.size() > 0) ent = exp_q.pop_front();
            check("tvalid", {62'd0, u_valid, s_valid}, exp_v ? 64'd3 : 64'd0);
            check("tready", {60'd0, u_dvd_ready, u_dvs_ready, s_dvd_ready, s_dvs_ready},
                  {60'd0, exp_rdy, exp_rdy});
            check("tdata_u", u_data, ent[127:64]);
            check("tdata_s", s_data, ent[63:0]);
            if (u_valid) obs_u = u_data;
            if (s_valid) obs_s = s_data;
            if (exp_v) begin
                m_last_u = ent[127:64];
                m_last_s = ent[63:0];
            end
            if (reset) begin
                m_busy = 0; m_got_a = 0; m_got_b = 0;
                m_last_u = '0; m_last_s = '0;
                exp_q.delete();
            end else if (abort) begin
                m_busy = 0; m_got_a = 0; m_got_b = 0;
                exp_q.delete();
            end else if (exp_v) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (dvd_valid && !m_got_a) begin m_got_a = 1; m_a = dvd_data; end
                if (dvs_valid && !m_got_b) begin m_got_b = 1; m_b = dvs_data; end
                if (m_got_a && m_got_b) begin
                    m_busy  = 1;
                    m_due   = cyc + LAT;
                    exp_q.push_back({ref_u(m_a, m_b), ref_s(m_a, m_b)});
                    m_got_a = 0;
                    m_got_b = 0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int da, input int db, input bit keep);
        bit done_a, done_b;
        int i;
        done_a = 0; done_b = 0; i = 0;
        while (!(done_a && done_b) && i < 200) begin
            @(posedge clk); #1;
            dvd_data  = a;
            dvs_data  = b;
            dvd_valid = !done_a && (i >= da);
            dvs_valid = !done_b && (i >= db);
            @(negedge clk);
            if (dvd_valid && u_dvd_ready) done_a = 1;
            if (dvs_valid && u_dvs_ready) done_b = 1;
            i++;
        end
        if (!(done_a && done_b)) check("send_timeout", {62'd0, done_a, done_b}, 64'd3);
        if (!keep) begin
            @(posedge clk); #1;
            dvd_valid = 0;
            dvs_valid = 0;
        end
    endtask

    task automatic finish_op();
        int n;
        n = 0;
        @(negedge clk);
        while (m_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (m_busy) check("done_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 255);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; abort = 0;
        dvd_valid = 0; dvs_valid = 0; dvd_data = '0; dvs_data = '0;
        obs_u = '0; obs_s = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        mon_en = 1;
        @(negedge clk);
        check("reset_tdata_u", u_data, 64'd0);
        check("reset_tdata_s", s_data, 64'd0);

        obs_u = '0;
        send(32'd100, 32'd7, 0, 0, 0);
        finish_op();
        check("u_100_7", obs_u, {32'd14, 32'd2});

        obs_s = '0;
        send(-32'sd7, 32'd2, 0, 0, 0);
        finish_op();
        check("s_m7_2", obs_s, {32'hFFFF_FFFD, 32'hFFFF_FFFF});

        obs_s = '0;
        send(32'd7, -32'sd2, 0, 0, 0);
        finish_op();
        check("s_7_m2", obs_s, {32'hFFFF_FFFD, 32'd1});

        obs_s = '0;
        send(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        finish_op();
        check("s_min_m1", obs_s, {32'h8000_0000, 32'd0});

        obs_u = '0;
        send(32'hFFFF_FFFF, 32'h10, 0, 5, 0);
        finish_op();
        check("u_stagger", obs_u, {32'h0FFF_FFFF, 32'hF});

        obs_u = '0; obs_s = '0;
        send(32'h1234, 32'd0, 0, 0, 0);
        finish_op();
        check("u_div0", obs_u, {32'hFFFF_FFFF, 32'h1234});
        check("s_div0", obs_s, {32'hFFFF_FFFF, 32'h1234});

        // Abort in the middle of RUN, then a clean op.
        obs_u = '0;
        send(32'd1000, 32'd3, 0, 0, 0);
        repeat (9) @(posedge clk);
        pulse_abort();
        repeat (40) @(posedge clk);
        check("abort_no_result", obs_u, 64'd0);
        send(32'd9, 32'd3, 0, 0, 0);
        finish_op();
        check("u_9_3_after_abort", obs_u, {32'd3, 32'd0});

        // Handshake coinciding with abort is discarded.
        @(posedge clk); #1;
        dvd_data = 32'd5; dvs_data = 32'd1; dvd_valid = 1; dvs_valid = 1; abort = 1;
        @(posedge clk); #1;
        dvd_valid = 0; dvs_valid = 0; abort = 0;
        repeat (3) @(posedge clk);

        // Partial capture dropped by abort.
        obs_u = '0;
        @(posedge clk); #1 dvd_data = 32'd40; dvd_valid = 1;
        @(posedge clk); #1 dvd_valid = 0;
        pulse_abort();
        send(32'd8, 32'd2, 0, 0, 0);
        finish_op();
        check("u_8_2_after_partial", obs_u, {32'd4, 32'd0});

        // Back-to-back with valid held high.
        send(32'd50, 32'd5, 0, 0, 1);
        send(32'd77, 32'd4, 0, 0, 0);
        finish_op();
        check("u_b2b_second", obs_u, {32'd19, 32'd1});

        // Reset in the middle of RUN.
        send(32'd12345, 32'd6, 0, 0, 0);
        repeat (15) @(posedge clk);
        pulse_reset();
        @(negedge clk);
        check("midrun_reset_tdata", u_data, 64'd0);
        obs_u = '0;
        send(32'd9, 32'd3, 0, 0, 0);
        finish_op();
        check("u_9_3_after_reset", obs_u, {32'd3, 32'd0});

        for (int t = 0; t < 60; t++) begin
            int r;
            send(pick(), pick(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                repeat ($urandom_range(0, 36)) @(posedge clk);
                pulse_abort();
            end else if (r == 1) begin
                repeat ($urandom_range(0, 36)) @(posedge clk);
                pulse_reset();
            end
            if ($urandom_range(0, 1) == 1) finish_op();
        end

        finish_op();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
